// File: rtl/easyaxi_slv_wr_ctrl_pkg.sv
// Shared AXI widths, burst/response encodings and slave write FSM states.
package easyaxi_slv_wr_ctrl_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_USER_W  = 4;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_BWAIT,
    ST_BRESP
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/easyaxi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
module easyaxi_burst_addr_gen
  import easyaxi_slv_wr_ctrl_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  addr,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_ADDR_W-1:0]  next_addr
);

  logic [AXI_ADDR_W-1:0] step;
  logic [AXI_ADDR_W-1:0] incr_addr;
  logic [AXI_ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = AXI_ADDR_W'(1) << size;
    incr_addr = addr + step;
    wrap_mask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
    case (burst)
      AXI_BURST_INCR: next_addr = incr_addr;
      AXI_BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/easyaxi_slv_wr_ctrl.sv
// AXI slave write controller: one burst at a time into a byte-strobed local memory.
// Optional macro EASYAXI_SLV_WR_STALL_EN inserts LFSR-driven wready stalls.
module easyaxi_slv_wr_ctrl
  import easyaxi_slv_wr_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned BRESP_DLY = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axi_slv_awvalid,
  output logic                         axi_slv_awready,
  input  logic [AXI_ID_W-1:0]          axi_slv_awid,
  input  logic [AXI_ADDR_W-1:0]        axi_slv_awaddr,
  input  logic [AXI_LEN_W-1:0]         axi_slv_awlen,
  input  logic [AXI_SIZE_W-1:0]        axi_slv_awsize,
  input  logic [AXI_BURST_W-1:0]       axi_slv_awburst,
  input  logic [AXI_USER_W-1:0]        axi_slv_awuser,
  input  logic                         axi_slv_wvalid,
  output logic                         axi_slv_wready,
  input  logic [AXI_DATA_W-1:0]        axi_slv_wdata,
  input  logic [AXI_DATA_W/8-1:0]      axi_slv_wstrb,
  input  logic                         axi_slv_wlast,
  input  logic [AXI_USER_W-1:0]        axi_slv_wuser,
  output logic                         axi_slv_bvalid,
  input  logic                         axi_slv_bready,
  output logic [AXI_ID_W-1:0]          axi_slv_bid,
  output logic [AXI_RESP_W-1:0]        axi_slv_bresp,
  output logic [AXI_USER_W-1:0]        axi_slv_buser,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_rd_idx,
  output logic [AXI_DATA_W-1:0]        dbg_rd_data
);

  localparam int unsigned STRB_W   = AXI_DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);

  wr_state_e               state;
  logic [AXI_ID_W-1:0]     id_q;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [AXI_LEN_W-1:0]    len_q;
  logic [AXI_SIZE_W-1:0]   size_q;
  logic [AXI_BURST_W-1:0]  burst_q;
  logic [AXI_USER_W-1:0]   user_q;
  logic [AXI_LEN_W-1:0]    beat_cnt;
  logic                    err_q;
  logic                    nowr_q;
  logic [3:0]              dly_cnt;
  logic [AXI_DATA_W-1:0]   mem [MEM_DEPTH];

  logic [AXI_ADDR_W-1:0]   next_addr;
  logic [IDX_W-1:0]        wr_idx;
  logic                    aw_hs, w_hs, b_hs;
  logic                    last_cnt, end_beat, err_beat;
  logic                    size_bad, burst_bad, wrap_bad;
  logic                    stall_nxt;
  logic                    unused_wuser;

  assign unused_wuser = ^axi_slv_wuser;

  assign aw_hs    = axi_slv_awvalid & axi_slv_awready;
  assign w_hs     = axi_slv_wvalid & axi_slv_wready;
  assign b_hs     = axi_slv_bvalid & axi_slv_bready;
  assign last_cnt = (beat_cnt == len_q);
  assign end_beat = axi_slv_wlast | last_cnt;
  assign err_beat = err_q | (axi_slv_wlast != last_cnt);

  assign size_bad  = axi_slv_awsize > AXI_SIZE_W'(ADDR_LSB);
  assign burst_bad = (axi_slv_awburst == 2'd3);
  assign wrap_bad  = (axi_slv_awburst == AXI_BURST_WRAP) && !wrap_len_ok(axi_slv_awlen);

  assign wr_idx      = addr_q[ADDR_LSB +: IDX_W];
  assign dbg_rd_data = mem[dbg_rd_idx];

  easyaxi_burst_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

`ifdef EASYAXI_SLV_WR_STALL_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // wready is registered, so it is driven from the LFSR value of the coming cycle.
  assign stall_nxt = lfsr_nxt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= lfsr_nxt;
  end
`else
  assign stall_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      axi_slv_awready <= 1'b0;
      axi_slv_wready  <= 1'b0;
      axi_slv_bvalid  <= 1'b0;
      axi_slv_bid     <= '0;
      axi_slv_bresp   <= '0;
      axi_slv_buser   <= '0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      user_q          <= '0;
      beat_cnt        <= '0;
      err_q           <= 1'b0;
      nowr_q          <= 1'b0;
      dly_cnt         <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            id_q            <= axi_slv_awid;
            addr_q          <= axi_slv_awaddr;
            len_q           <= axi_slv_awlen;
            size_q          <= axi_slv_awsize;
            burst_q         <= axi_slv_awburst;
            user_q          <= axi_slv_awuser;
            beat_cnt        <= '0;
            // Header-level errors are known at AW time, so the flag starts pre-set.
            err_q           <= size_bad | burst_bad | wrap_bad;
            nowr_q          <= size_bad | burst_bad;
            axi_slv_awready <= 1'b0;
            axi_slv_wready  <= ~stall_nxt;
            state           <= ST_WDATA;
          end else begin
            axi_slv_awready <= 1'b1;
          end
        end
        ST_WDATA: begin
          axi_slv_wready <= ~stall_nxt;
          if (w_hs) begin
            if (!nowr_q) begin
              for (int unsigned b = 0; b < STRB_W; b++)
                if (axi_slv_wstrb[b]) mem[wr_idx][b*8 +: 8] <= axi_slv_wdata[b*8 +: 8];
            end
            addr_q   <= next_addr;
            beat_cnt <= beat_cnt + 1'b1;
            err_q    <= err_beat;
            if (end_beat) begin
              axi_slv_wready <= 1'b0;
              if (BRESP_DLY > 0) begin
                dly_cnt <= 4'(BRESP_DLY - 1);
                state   <= ST_BWAIT;
              end else begin
                axi_slv_bvalid <= 1'b1;
                axi_slv_bid    <= id_q;
                axi_slv_bresp  <= err_beat ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                axi_slv_buser  <= user_q;
                state          <= ST_BRESP;
              end
            end
          end
        end
        ST_BWAIT: begin
          if (dly_cnt == 4'd0) begin
            axi_slv_bvalid <= 1'b1;
            axi_slv_bid    <= id_q;
            axi_slv_bresp  <= err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            axi_slv_buser  <= user_q;
            state          <= ST_BRESP;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        ST_BRESP: begin
          if (b_hs) begin
            axi_slv_bvalid  <= 1'b0;
            axi_slv_awready <= 1'b1;
            err_q           <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_easyaxi_slv_wr_ctrl.sv
// Directed self-checking bench for easyaxi_slv_wr_ctrl (default parameters, no stall).
module tb_easyaxi_slv_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [3:0]  awuser = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic [3:0]  wuser = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [3:0]  buser;
  logic [3:0]  dbg_rd_idx = '0;
  logic [31:0] dbg_rd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  easyaxi_slv_wr_ctrl #(.MEM_DEPTH(16), .BRESP_DLY(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_awvalid (awvalid),
    .axi_slv_awready (awready),
    .axi_slv_awid    (awid),
    .axi_slv_awaddr  (awaddr),
    .axi_slv_awlen   (awlen),
    .axi_slv_awsize  (awsize),
    .axi_slv_awburst (awburst),
    .axi_slv_awuser  (awuser),
    .axi_slv_wvalid  (wvalid),
    .axi_slv_wready  (wready),
    .axi_slv_wdata   (wdata),
    .axi_slv_wstrb   (wstrb),
    .axi_slv_wlast   (wlast),
    .axi_slv_wuser   (wuser),
    .axi_slv_bvalid  (bvalid),
    .axi_slv_bready  (bready),
    .axi_slv_bid     (bid),
    .axi_slv_bresp   (bresp),
    .axi_slv_buser   (buser),
    .dbg_rd_idx      (dbg_rd_idx),
    .dbg_rd_data     (dbg_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    dbg_rd_idx = idx;
    #1;
    check(tag, 64'(dbg_rd_data), 64'(exp));
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] user);
    int n = 0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awuser = user;
    awvalid = 1'b1;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("aw_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    @(negedge clk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("w_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp,
                        input logic [3:0] user);
    int n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_b_timeout"}, 64'(n), 64'(0));
    check({tag, "_bid"}, 64'(bid), 64'(id));
    check({tag, "_bresp"}, 64'(bresp), 64'(resp));
    check({tag, "_buser"}, 64'(buser), 64'(user));
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    check({tag, "_bvalid_drop"}, 64'(bvalid), 64'(0));
    check({tag, "_awready_back"}, 64'(awready), 64'(1));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #12;
    // Reset state
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_bid", 64'(bid), 64'(0));
    check("rst_bresp", 64'(bresp), 64'(0));
    check("rst_buser", 64'(buser), 64'(0));
    peek("rst_mem0", 4'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("awready_pre_edge", 64'(awready), 64'(0));
    @(negedge clk);
    check("awready_after_edge", 64'(awready), 64'(1));

    // W beat offered while idle must be ignored
    wvalid = 1'b1; wdata = 32'hCAFEBABE; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    check("idle_wready", 64'(wready), 64'(0));
    wvalid = 1'b0; wlast = 1'b0;
    peek("idle_w_nowrite", 4'd0, 32'h0);

    // INCR burst
    aw_send(4'd3, 32'h0, 8'd3, 3'd2, 2'd1, 4'd5);
    check("incr_awready_low", 64'(awready), 64'(0));
    check("incr_wready_high", 64'(wready), 64'(1));
    w_beat(32'h11, 4'hF, 1'b0);
    w_beat(32'h22, 4'hF, 1'b0);
    w_beat(32'h33, 4'hF, 1'b0);
    w_beat(32'h44, 4'hF, 1'b1);
    check("incr_bvalid_lat1", 64'(bvalid), 64'(1));
    check("incr_wready_low", 64'(wready), 64'(0));
    b_recv("incr", 4'd3, 2'd0, 4'd5);
    peek("incr_mem0", 4'd0, 32'h11);
    peek("incr_mem1", 4'd1, 32'h22);
    peek("incr_mem2", 4'd2, 32'h33);
    peek("incr_mem3", 4'd3, 32'h44);

    // WRAP burst from 0x8: 2,3,0,1
    aw_send(4'd1, 32'h8, 8'd3, 3'd2, 2'd2, 4'd2);
    w_beat(32'hA0, 4'hF, 1'b0);
    w_beat(32'hA1, 4'hF, 1'b0);
    w_beat(32'hA2, 4'hF, 1'b0);
    w_beat(32'hA3, 4'hF, 1'b1);
    b_recv("wrap", 4'd1, 2'd0, 4'd2);
    peek("wrap_mem2", 4'd2, 32'hA0);
    peek("wrap_mem3", 4'd3, 32'hA1);
    peek("wrap_mem0", 4'd0, 32'hA2);
    peek("wrap_mem1", 4'd1, 32'hA3);

    // Partial strobe
    aw_send(4'd2, 32'h14, 8'd0, 3'd2, 2'd1, 4'd0);
    w_beat(32'hFFFFFFFF, 4'hF, 1'b1);
    b_recv("fill5", 4'd2, 2'd0, 4'd0);
    aw_send(4'd2, 32'h14, 8'd0, 3'd2, 2'd1, 4'd0);
    w_beat(32'h12345678, 4'h5, 1'b1);
    b_recv("strb5", 4'd2, 2'd0, 4'd0);
    peek("strb_mem5", 4'd5, 32'hFF34FF78);

    // Early wlast on beat 1 of len=3
    aw_send(4'd4, 32'h20, 8'd3, 3'd2, 2'd1, 4'd6);
    w_beat(32'h51, 4'hF, 1'b0);
    w_beat(32'h52, 4'hF, 1'b1);
    check("early_wready_low", 64'(wready), 64'(0));
    b_recv("early", 4'd4, 2'd2, 4'd6);
    peek("early_mem8", 4'd8, 32'h51);
    peek("early_mem9", 4'd9, 32'h52);
    peek("early_mem10", 4'd10, 32'h0);

    // Oversized beat: SLVERR, no memory write, beats consumed
    aw_send(4'd5, 32'h0, 8'd1, 3'd3, 2'd1, 4'd1);
    w_beat(32'hDEAD0000, 4'hF, 1'b0);
    w_beat(32'hDEAD0001, 4'hF, 1'b1);
    b_recv("size", 4'd5, 2'd2, 4'd1);
    peek("size_mem0", 4'd0, 32'hA2);
    peek("size_mem1", 4'd1, 32'hA3);

    // B backpressure with a competing AW
    aw_send(4'd7, 32'h28, 8'd0, 3'd2, 2'd1, 4'd9);
    w_beat(32'h77, 4'hF, 1'b1);
    awid = 4'd2; awaddr = 32'h2C; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awuser = 4'd3;
    awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_bvalid", 64'(bvalid), 64'(1));
      check("bp_bid", 64'(bid), 64'(7));
      check("bp_bresp", 64'(bresp), 64'(0));
      check("bp_awready", 64'(awready), 64'(0));
    end
    b_recv("bp", 4'd7, 2'd0, 4'd9);
    aw_send(4'd2, 32'h2C, 8'd0, 3'd2, 2'd1, 4'd3);
    w_beat(32'h88, 4'hF, 1'b1);
    b_recv("bp_next", 4'd2, 2'd0, 4'd3);
    peek("bp_mem10", 4'd10, 32'h77);
    peek("bp_mem11", 4'd11, 32'h88);

    // Reset mid-burst after 2 of 4 beats
    aw_send(4'd6, 32'h30, 8'd3, 3'd2, 2'd1, 4'd4);
    w_beat(32'h61, 4'hF, 1'b0);
    w_beat(32'h62, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_awready", 64'(awready), 64'(0));
    check("mid_rst_wready", 64'(wready), 64'(0));
    check("mid_rst_bvalid", 64'(bvalid), 64'(0));
    peek("mid_rst_mem12", 4'd12, 32'h0);
    peek("mid_rst_mem5", 4'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_b", 64'(bvalid), 64'(0));
    end
    rst_n = 1'b1;
    aw_send(4'd8, 32'h4, 8'd0, 3'd2, 2'd0, 4'd7);
    w_beat(32'hBEEF, 4'hF, 1'b1);
    b_recv("post_rst", 4'd8, 2'd0, 4'd7);
    peek("post_rst_mem1", 4'd1, 32'hBEEF);
    peek("post_rst_mem0", 4'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
